// File: rtl/eq_test_pkg.sv
// Shared types and width helpers for the eq comparator self-test block.
//   eq_test_state_t : checker FSM states
//   n_vec(width)    : number of x/y vectors for a given operand width
//   idx_w(width)    : vector index width (2*width)
//   err_w(width)    : error counter width (2*width+1, holds n_vec without wrapping)
package eq_test_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StCheck,
      StDone
   } eq_test_state_t;

   function automatic int unsigned n_vec(input int unsigned width);
      return 32'd1 << (2 * width);
   endfunction

   function automatic int unsigned idx_w(input int unsigned width);
      return 2 * width;
   endfunction

   function automatic int unsigned err_w(input int unsigned width);
      return 2 * width + 1;
   endfunction

endpackage

// File: rtl/eq_stim_checker_if.sv
// Bundle between the self-test checker and its surroundings.
//   start      : run request into the checker
//   s          : result returned by the eq under test
//   x, y       : operands driven to the eq under test
//   busy, done : run status (done is a one-cycle pulse)
//   pass       : last completed run had no mismatches
//   err_count  : mismatching vectors in the current/last run
//   first_fail : index of the first mismatching vector
// master = checker side, slave = eq/controller side.
interface eq_stim_checker_if #(
   parameter int unsigned WIDTH = 1
);
   logic                 start;
   logic                 s;
   logic [WIDTH-1:0]     x;
   logic [WIDTH-1:0]     y;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [2*WIDTH:0]     err_count;
   logic [2*WIDTH-1:0]   first_fail;

   modport master (
      input  start, s,
      output x, y, busy, done, pass, err_count, first_fail
   );

   modport slave (
      output start, s,
      input  x, y, busy, done, pass, err_count, first_fail
   );
endinterface

// File: rtl/eq_hold_timer.sv
// Hold timer for the checker: counts 0..HOLD-1 while en is high and flags
// the final count so the caller can sample on that edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return to count 0
//   en         : count this cycle
//   expire     : en is high and the count is HOLD-1 (counter wraps to 0)
module eq_hold_timer #(
   parameter int unsigned HOLD = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic expire
);

   // HOLD = 1 still needs a one-bit counter to keep widths legal.
   localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD - 1);

   logic [CNT_W-1:0] cnt_q;

   assign expire = en && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= expire ? '0 : cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/eq_stim_checker.sv
// Synthesizable self-test initiator for the eq comparator. Walks every x/y
// combination, holds each for HOLD cycles, samples s on the last hold edge,
// and compares it with x == y. Reports pass, a mismatch count and the first
// failing vector index.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : master side of eq_stim_checker_if (start/s in, x/y/status out)
module eq_stim_checker
   import eq_test_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned HOLD  = 50
) (
   input  logic                clk,
   input  logic                rst_n,
   eq_stim_checker_if.master   bus
);

   localparam int unsigned IDX_W = idx_w(WIDTH);
   localparam int unsigned ERR_W = err_w(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(n_vec(WIDTH) - 1);

   eq_test_state_t     state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [WIDTH-1:0]   x_q;
   logic [WIDTH-1:0]   y_q;
   logic               s_q;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;
   logic [ERR_W-1:0]   err_q;
   logic [IDX_W-1:0]   first_q;

   logic               expire;
   logic               mismatch;
   logic [IDX_W-1:0]   idx_nxt;

   eq_hold_timer #(
      .HOLD (HOLD)
   ) u_hold_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_q != StDrive),
      .en     (state_q == StDrive),
      .expire (expire)
   );

   // x_q/y_q always hold the vector under check, so the expectation comes
   // straight from them.
   assign mismatch = (s_q != (x_q == y_q));
   assign idx_nxt  = idx_q + IDX_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         s_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         first_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  err_q   <= '0;
                  first_q <= '0;
                  pass_q  <= 1'b0;
                  idx_q   <= '0;
                  x_q     <= '0;
                  y_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StDrive;
               end
            end
            StDrive: begin
               if (expire) begin
                  s_q     <= bus.s;
                  state_q <= StCheck;
               end
            end
            StCheck: begin
               if (mismatch) begin
                  err_q <= err_q + ERR_W'(1);
                  if (err_q == '0) begin
                     first_q <= idx_q;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  // Latch pass together with done so both are valid in the pulse cycle.
                  pass_q  <= (err_q == '0) && !mismatch;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  idx_q   <= idx_nxt;
                  x_q     <= idx_nxt[IDX_W-1:WIDTH];
                  y_q     <= idx_nxt[WIDTH-1:0];
                  state_q <= StDrive;
               end
            end
            StDone: begin
               x_q     <= '0;
               y_q     <= '0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_count  = err_q;
   assign bus.first_fail = first_q;

endmodule

// File: tb/tb_eq_stim_checker.sv
module tb_eq_stim_checker;

   typedef struct {
      string tag;
      int    err;
      int    first;
      int    pass;
      int    done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   mode_a = 0;   // 0: correct eq, 1: s stuck at 1, 2: s inverted
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   eq_stim_checker_if #(.WIDTH(1)) bus_a ();
   eq_stim_checker_if #(.WIDTH(2)) bus_b ();

   assign bus_a.s = (mode_a == 0) ? (bus_a.x == bus_a.y) :
                    (mode_a == 1) ? 1'b1 : (bus_a.x != bus_a.y);
   assign bus_b.s = (bus_b.x == bus_b.y);

   eq_stim_checker #(.WIDTH(1), .HOLD(50)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   eq_stim_checker #(.WIDTH(2), .HOLD(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Independent reference: walk all vectors with the chosen eq behaviour.
   task automatic push_exp(input string tag, input int mode, input int w, input int done_cyc);
      exp_t e;
      int   n;
      e.tag = tag;
      e.err = 0;
      e.first = 0;
      e.done_cyc = done_cyc;
      n = 1 << (2 * w);
      for (int v = 0; v < n; v++) begin
         int  xx;
         int  yy;
         bit  ex;
         bit  sv;
         xx = v >> w;
         yy = v & ((1 << w) - 1);
         ex = (xx == yy);
         sv = (mode == 0) ? ex : (mode == 1) ? 1'b1 : !ex;
         if (sv != ex) begin
            if (e.err == 0) e.first = v;
            e.err++;
         end
      end
      e.pass = (e.err == 0) ? 1 : 0;
      sb.push_back(e);
   endtask

   task automatic start_a(output int c);
      @(negedge clk);
      bus_a.start = 1'b1;
      c = cyc;
      @(negedge clk);
      bus_a.start = 1'b0;
   endtask

   task automatic check_vectors_a(input string tag, input int c);
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 400 && cyc < c + 1 + v * 51; i++) @(negedge clk);
         chk({tag, " vec"}, 32'({bus_a.x, bus_a.y}), v);
         chk({tag, " busy"}, 32'(bus_a.busy), 1);
      end
   endtask

   task automatic finish_a();
      exp_t e;
      int   at;
      at = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus_a.done === 1'b1) begin
            at = cyc;
            break;
         end
      end
      e = sb.pop_front();
      chk({e.tag, " done_cyc"}, at, e.done_cyc);
      chk({e.tag, " err_count"}, 32'(bus_a.err_count), e.err);
      chk({e.tag, " first_fail"}, 32'(bus_a.first_fail), e.first);
      chk({e.tag, " pass"}, 32'(bus_a.pass), e.pass);
      chk({e.tag, " busy_in_done"}, 32'(bus_a.busy), 0);
      @(negedge clk);
      chk({e.tag, " done_pulse"}, 32'(bus_a.done), 0);
      chk({e.tag, " pass_hold"}, 32'(bus_a.pass), e.pass);
   endtask

   task automatic check_reset_a(input string tag);
      chk({tag, " x"}, 32'(bus_a.x), 0);
      chk({tag, " y"}, 32'(bus_a.y), 0);
      chk({tag, " busy"}, 32'(bus_a.busy), 0);
      chk({tag, " done"}, 32'(bus_a.done), 0);
      chk({tag, " pass"}, 32'(bus_a.pass), 0);
      chk({tag, " err"}, 32'(bus_a.err_count), 0);
      chk({tag, " first"}, 32'(bus_a.first_fail), 0);
   endtask

   initial begin
      int c;
      int c2;
      int at;
      exp_t e;

      rst_n = 1'b0;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_a("reset");
      chk("reset b busy", 32'(bus_b.busy), 0);
      chk("reset b err", 32'(bus_b.err_count), 0);
      rst_n = 1'b1;

      // Correct eq, start seen during cycle 10 -> done at cycle 215.
      while (cyc < 9) @(negedge clk);
      start_a(c);
      push_exp("good", 0, 1, c + 205);
      check_vectors_a("good", c);
      finish_a();

      mode_a = 1;
      start_a(c);
      push_exp("stuck1", 1, 1, c + 205);
      check_vectors_a("stuck1", c);
      finish_a();

      mode_a = 2;
      start_a(c);
      push_exp("invert", 2, 1, c + 205);
      finish_a();

      // start re-pulsed while busy must not restart the run.
      mode_a = 0;
      start_a(c);
      push_exp("repulse", 0, 1, c + 205);
      for (int i = 0; i < 60; i++) @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      for (int i = 0; i < 80; i++) @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      finish_a();

      // start held across DONE -> IDLE launches the next run straight away.
      @(negedge clk);
      bus_a.start = 1'b1;
      c = cyc;
      push_exp("held1", 0, 1, c + 205);
      finish_a();
      c2 = cyc;   // IDLE cycle after DONE; accepted on the coming edge
      push_exp("held2", 0, 1, c2 + 205);
      chk("held idle busy", 32'(bus_a.busy), 0);
      @(negedge clk);
      bus_a.start = 1'b0;
      chk("held2 busy", 32'(bus_a.busy), 1);
      chk("held2 vec0", 32'({bus_a.x, bus_a.y}), 0);
      finish_a();

      // Asynchronous reset during vector 2 clears everything mid-cycle.
      mode_a = 2;
      start_a(c);
      for (int i = 0; i < 400 && cyc < c + 1 + 2 * 51 + 10; i++) @(negedge clk);
      chk("pre_reset err", 32'(bus_a.err_count), 2);
      #2 rst_n = 1'b0;
      #1 check_reset_a("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      mode_a = 0;
      start_a(c);
      push_exp("after_reset", 0, 1, c + 205);
      check_vectors_a("after_reset", c);
      finish_a();

      // WIDTH=2, HOLD=1: 16 vectors at 2 cycles each.
      @(negedge clk);
      bus_b.start = 1'b1;
      c = cyc;
      @(negedge clk);
      bus_b.start = 1'b0;
      push_exp("w2h1", 0, 2, c + 33);
      for (int v = 0; v < 16; v++) begin
         for (int i = 0; i < 100 && cyc < c + 1 + v * 2; i++) @(negedge clk);
         chk("w2h1 vec", 32'({bus_b.x, bus_b.y}), v);
      end
      at = -1;
      for (int i = 0; i < 100; i++) begin
         if (bus_b.done === 1'b1) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
      e = sb.pop_front();
      chk({e.tag, " done_cyc"}, at, e.done_cyc);
      chk({e.tag, " err_count"}, 32'(bus_b.err_count), e.err);
      chk({e.tag, " pass"}, 32'(bus_b.pass), e.pass);
      chk({e.tag, " busy_in_done"}, 32'(bus_b.busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
